// File: rtl/bcp_pkg.sv
// Shared BCP datapath types: variable index, implication record, queue FSM states.
// Also holds the saturating-increment helper used by the optional statistics counters.
package bcp_pkg;

  localparam int VAR_W    = 9;
  localparam int NUM_VARS = 2 ** VAR_W;

  typedef logic [VAR_W-1:0] var_idx_t;

  // "var" is a reserved word, so the variable index field is named vid.
  typedef struct packed {
    var_idx_t vid;
    logic     value;
  } implication_t;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_CONFLICT = 1'b1
  } implq_state_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == STAT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/implq_fifo.sv
// Plain DEPTH-entry synchronous FIFO of implication_t records.
// Pointers wrap modulo DEPTH; the caller guarantees no overflow or underflow.
module implq_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  implication_t             wdata,
  output implication_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  implication_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  // Storage, pointers and occupancy; clr empties the queue synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == {(AW+1){1'b0}});

endmodule

// File: rtl/implication_queue.sv
// BCP implication queue: dedupes unit implications, detects opposite-polarity conflicts,
// and hands implications downstream one per cycle. Optional macro IMPLQ_STATS_EN adds counters.
module implication_queue
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    in_unit,
  input  logic [VAR_W-1:0]        in_var,
  input  logic                    in_value,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [VAR_W-1:0]        out_var,
  output logic                    out_value,
  input  logic                    out_ready,
  output logic                    conflict,
  output logic [VAR_W-1:0]        conflict_var,
  output logic [$clog2(DEPTH):0]  count
`ifdef IMPLQ_STATS_EN
  ,
  output logic [15:0]             stat_push,
  output logic [15:0]             stat_dup,
  output logic [15:0]             stat_conf
`endif
);

  implq_state_t          state;
  implq_state_t          state_next;
  logic [NUM_VARS-1:0]   pend;
  logic [NUM_VARS-1:0]   pval;
  implication_t          head;
  implication_t          wr_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push_req;
  logic                  hit;
  logic                  same;
  logic                  do_enq;
  logic                  do_dup;
  logic                  do_conf;

  // Handshake: the queue is frozen (no output, no input) while a conflict is pending.
  assign out_valid = (state == ST_RUN) & ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (state == ST_RUN) & (~fifo_full | pop);
  assign out_var   = out_valid ? head.vid : {VAR_W{1'b0}};
  assign out_value = out_valid & head.value;
  assign conflict  = (state == ST_CONFLICT);

  // The check uses the registered table, so a var popped this cycle still counts as pending.
  assign push_req = in_valid & in_unit & (in_var != {VAR_W{1'b0}}) & in_ready;
  assign hit      = pend[in_var];
  assign same     = (pval[in_var] == in_value);
  assign do_enq   = push_req & ~flush & ~hit;
  assign do_dup   = push_req & ~flush & hit & same;
  assign do_conf  = push_req & ~flush & hit & ~same;
  assign wr_entry = {in_var, in_value};

  implq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (do_enq),
    .pop   (pop & ~flush),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Pending table mirrors FIFO contents; enqueue never targets the popped var.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= {NUM_VARS{1'b0}};
      pval <= {NUM_VARS{1'b0}};
    end else if (flush) begin
      pend <= {NUM_VARS{1'b0}};
      pval <= {NUM_VARS{1'b0}};
    end else begin
      if (pop) begin
        pend[head.vid] <= 1'b0;
      end
      if (do_enq) begin
        pend[in_var] <= 1'b1;
        pval[in_var] <= in_value;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only a flush leaves CONFLICT.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (do_conf) begin
          state_next = ST_CONFLICT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_CONFLICT: state_next = ST_CONFLICT;
      default:     state_next = ST_RUN;
    endcase
    if (flush) begin
      state_next = ST_RUN;
    end else begin
      state_next = state_next;
    end
  end

  // First conflicting variable; do_conf implies RUN, so it is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_var <= {VAR_W{1'b0}};
    end else if (flush) begin
      conflict_var <= {VAR_W{1'b0}};
    end else if (do_conf) begin
      conflict_var <= in_var;
    end else begin
      conflict_var <= conflict_var;
    end
  end

`ifdef IMPLQ_STATS_EN
  // Saturating event counters; deliberately survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_push <= 16'd0;
      stat_dup  <= 16'd0;
      stat_conf <= 16'd0;
    end else begin
      if (do_enq) begin
        stat_push <= sat_inc16(stat_push);
      end
      if (do_dup) begin
        stat_dup <= sat_inc16(stat_dup);
      end
      if (do_conf) begin
        stat_conf <= sat_inc16(stat_conf);
      end
    end
  end
`endif

endmodule

// File: tb/tb_implication_queue.sv
// Bench for implication_queue: table vectors, hand sequences and random traffic vs a queue model.
module tb_implication_queue;
  import bcp_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_unit = 1'b0;
  logic [VAR_W-1:0] in_var = '0;
  logic             in_value = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [VAR_W-1:0] out_var;
  logic             out_value;
  logic             conflict;
  logic [VAR_W-1:0] conflict_var;
  logic [CW-1:0]    count;
`ifdef IMPLQ_STATS_EN
  logic [15:0]      stat_push;
  logic [15:0]      stat_dup;
  logic [15:0]      stat_conf;
`endif

  implication_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_unit(in_unit), .in_var(in_var), .in_value(in_value),
    .in_ready(in_ready), .out_valid(out_valid), .out_var(out_var), .out_value(out_value),
    .out_ready(out_ready), .conflict(conflict), .conflict_var(conflict_var), .count(count)
`ifdef IMPLQ_STATS_EN
    , .stat_push(stat_push), .stat_dup(stat_dup), .stat_conf(stat_conf)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct { int v; int b; } ent_t;
  ent_t q[$];
  int   m_conf = 0;
  int   m_cvar = 0;
  int   m_push = 0;
  int   m_dup  = 0;
  int   m_nconf = 0;

  typedef struct {
    int f, v, u, vr, val, ordy;
    int e_ov, e_var, e_val, e_ir, e_cnt, e_conf, e_cvar;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input int f, input int v, input int u, input int vr, input int val, input int ordy);
    flush     = (f != 0);
    in_valid  = (v != 0);
    in_unit   = (u != 0);
    in_var    = VAR_W'(vr);
    in_value  = (val != 0);
    out_ready = (ordy != 0);
  endtask

  // Expected outputs follow from the queue contents and the conflict flag alone.
  task automatic check_model();
    int mv;
    int mr;
    mv = (m_conf == 0 && q.size() > 0) ? 1 : 0;
    mr = (m_conf == 0 && (q.size() < DEPTH || (mv == 1 && out_ready))) ? 1 : 0;
    chk("m_out_valid", 32'(out_valid), 32'(mv));
    if (mv == 1) begin
      chk("m_out_var", 32'(out_var), 32'(q[0].v));
      chk("m_out_value", 32'(out_value), 32'(q[0].b));
    end
    chk("m_in_ready", 32'(in_ready), 32'(mr));
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_conflict", 32'(conflict), 32'(m_conf));
    chk("m_conflict_var", 32'(conflict_var), 32'(m_cvar));
  endtask

  task automatic update_model();
    int mv;
    int mr;
    int idx;
    int enq;
    mv  = (m_conf == 0 && q.size() > 0) ? 1 : 0;
    mr  = (m_conf == 0 && (q.size() < DEPTH || (mv == 1 && out_ready))) ? 1 : 0;
    idx = -1;
    enq = 0;
    if (flush) begin
      q.delete();
      m_conf = 0;
      m_cvar = 0;
    end else begin
      if (in_valid && in_unit && in_var != 0 && mr == 1) begin
        foreach (q[i]) if (q[i].v == int'(in_var)) idx = i;
        if (idx < 0) begin
          enq = 1;
          m_push++;
        end else if (q[idx].b == int'(in_value)) begin
          m_dup++;
        end else begin
          m_conf = 1;
          m_cvar = int'(in_var);
          m_nconf++;
        end
      end
      if (mv == 1 && out_ready) void'(q.pop_front());
      if (enq == 1) q.push_back('{v: int'(in_var), b: int'(in_value)});
    end
  endtask

  task automatic step();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int f, input int v, input int u, input int vr, input int val, input int ordy);
    set_in(f, v, u, vr, val, ordy);
    #1;
    check_model();
    step();
  endtask

`ifdef IMPLQ_STATS_EN
  task automatic check_stats();
    chk("stat_push", 32'(stat_push), 32'(m_push));
    chk("stat_dup", 32'(stat_dup), 32'(m_dup));
    chk("stat_conf", 32'(stat_conf), 32'(m_nconf));
  endtask
`endif

  initial begin
    //        f  v  u  var val rdy  ov var val ir cnt cf cvar
    tbl[0]  = '{0, 1, 1, 5,  1, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,  0, 1,   1, 5, 1, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 7,  0, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 7,  0, 0,   1, 7, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,  0, 0,   1, 7, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,  0, 1,   1, 7, 0, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 9,  1, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 9,  0, 0,   1, 9, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0,  0, 1,   0, 0, 0, 0, 1, 1, 9};
    tbl[11] = '{1, 0, 0, 0,  0, 0,   0, 0, 0, 0, 1, 1, 9};
    tbl[12] = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 0,  1, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 11, 1, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[16] = '{1, 1, 1, 12, 1, 0,   0, 0, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 0,  0, 0,   0, 0, 0, 1, 0, 0, 0};

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_var", 32'(out_var), 32'd0);
    chk("rst_out_value", 32'(out_value), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_conflict_var", 32'(conflict_var), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenarios 1, 2, 3 and 5 as a vector table.
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].f, tbl[i].v, tbl[i].u, tbl[i].vr, tbl[i].val, tbl[i].ordy);
      #1;
      check_model();
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov != 0) begin
        chk($sformatf("tbl%0d_out_var", i), 32'(out_var), 32'(tbl[i].e_var));
        chk($sformatf("tbl%0d_out_value", i), 32'(out_value), 32'(tbl[i].e_val));
      end
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_conflict", i), 32'(conflict), 32'(tbl[i].e_conf));
      chk($sformatf("tbl%0d_conflict_var", i), 32'(conflict_var), 32'(tbl[i].e_cvar));
      step();
    end

    // Scenario 4: fill, push+pop at full, pointer wrap.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) cyc(0, 1, 1, i, i % 2, 0);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check_model();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    step();
    set_in(0, 1, 1, 100, 1, 1);
    #1;
    check_model();
    chk("full_pushpop_ready", 32'(in_ready), 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check_model();
    chk("pushpop_count", 32'(count), 32'd16);
    chk("pushpop_head", 32'(out_var), 32'd2);
    step();
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 200 + i, i % 2, 1);
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check_model();
    chk("wrap_head_var", 32'(out_var), 32'd224);
    chk("wrap_head_value", 32'(out_value), 32'd0);
    chk("wrap_count", 32'(count), 32'd16);
    step();

    // Scenario 6: pop head (3,1) while pushing (3,0).
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 1, 0);
    set_in(0, 1, 1, 3, 0, 1);
    #1;
    check_model();
    chk("s6_head_var", 32'(out_var), 32'd3);
    chk("s6_in_ready", 32'(in_ready), 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check_model();
    chk("s6_conflict", 32'(conflict), 32'd1);
    chk("s6_conflict_var", 32'(conflict_var), 32'd3);
    chk("s6_out_valid", 32'(out_valid), 32'd0);
    chk("s6_in_ready_frozen", 32'(in_ready), 32'd0);
    chk("s6_count", 32'(count), 32'd0);
    step();
`ifdef IMPLQ_STATS_EN
    chk("s6_stat_push", 32'(stat_push), 32'd61);
    chk("s6_stat_dup", 32'(stat_dup), 32'd1);
    chk("s6_stat_conf", 32'(stat_conf), 32'd2);
    check_stats();
`endif
    cyc(1, 0, 0, 0, 0, 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      int f;
      int vr;
      int ordy;
      f    = (m_conf != 0) ? int'($urandom_range(0, 7) == 0) : int'($urandom_range(0, 59) == 0);
      vr   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      ordy = (i < 300) ? int'($urandom_range(0, 2) == 0) : int'($urandom_range(0, 2) != 0);
      cyc(f, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4) != 0), vr,
          int'($urandom_range(0, 1)), ordy);
    end
`ifdef IMPLQ_STATS_EN
    check_stats();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
